// File: rtl/mvd_defines.sv
// Shared definitions for the MV-candidate fetch path: region codes,
// read-port select encodings, fetch FSM states and small decode helpers.
package mvd_defines;

    // Candidate region codes carried in the top two address bits.
    localparam logic [1:0] CAN_NONE = 2'b00;
    localparam logic [1:0] CAN_NBR  = 2'b01;
    localparam logic [1:0] CAN_CUR  = 2'b10;

    // MV storage selects presented to the read-port arbiter.
    localparam logic [1:0] RD_SEL_NONE = 2'd0;
    localparam logic [1:0] RD_SEL_LEFT = 2'd1;
    localparam logic [1:0] RD_SEL_TOP  = 2'd2;
    localparam logic [1:0] RD_SEL_CUR  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_A,
        ST_REQ_B,
        ST_DRAIN,
        ST_DONE
    } fetch_state_e;

    // A candidate is fetched only for the two defined region codes; the
    // reserved code 11 behaves exactly like "no candidate".
    function automatic logic cand_present(input logic [1:0] code);
        return (code == CAN_NBR) || (code == CAN_CUR);
    endfunction

    // Neighbour code maps to the left column for A and the top line for B.
    function automatic logic [1:0] cand_sel(input logic [1:0] code, input logic is_b);
        logic [1:0] sel;
        sel = RD_SEL_NONE;
        case (code)
            CAN_NBR: sel = is_b ? RD_SEL_TOP : RD_SEL_LEFT;
            CAN_CUR: sel = RD_SEL_CUR;
            default: sel = RD_SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mvd_rd_tag_pipe.sv
// RD_LAT-deep shift register of {vld, is_b} tags that follows each granted
// read until its data returns; the tail stage lines up with rd_data.
module mvd_rd_tag_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic is_b_i,
    output logic tail_vld_o,
    output logic tail_is_b_o,
    output logic inflight_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] isb_q;
    logic [RD_LAT:0]   vld_ext;
    logic [RD_LAT:0]   isb_ext;

    // Stage 0 takes the new tag, the top bit of the extended vector is the
    // stage leaving the pipe this cycle.
    assign vld_ext = {vld_q, load_i};
    assign isb_ext = {isb_q, is_b_i};

    assign tail_vld_o  = vld_ext[RD_LAT];
    assign tail_is_b_o = isb_ext[RD_LAT];
    // Tags still in the pipe once this cycle's tail has been consumed.
    assign inflight_o  = |vld_ext[RD_LAT-1:0];

    // Advance the tag pipe; reset flushes any outstanding returns.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            vld_q <= '0;
            isb_q <= '0;
        end else begin
            vld_q <= vld_ext[RD_LAT-1:0];
            isb_q <= isb_ext[RD_LAT-1:0];
        end
    end

endmodule

// File: rtl/mvd_can_mv_fetch_ctrl.sv
// Fetches the spatial A (left) and B (top) MV candidates of one PU over a
// shared, arbitrated MV read port and returns both MVs with valid flags.
module mvd_can_mv_fetch_ctrl
    import mvd_defines::*;
#(
    parameter int MV_W   = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [7:0]      a_addr_i,
    input  logic [8:0]      b_addr_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            rd_req_o,
    output logic [1:0]      rd_sel_o,
    output logic [6:0]      rd_addr_o,
    input  logic            rd_gnt_i,
    input  logic [MV_W-1:0] rd_data_i,
    output logic [MV_W-1:0] mv_a_o,
    output logic            mv_a_valid_o,
    output logic [MV_W-1:0] mv_b_o,
    output logic            mv_b_valid_o
);

    fetch_state_e    state_q, state_d;
    logic [7:0]      a_addr_q;
    logic [8:0]      b_addr_q;
    logic [MV_W-1:0] mv_a_q, mv_b_q;
    logic            mv_a_vld_q, mv_b_vld_q;

    logic            accept;
    logic            granted;
    logic            tail_vld;
    logic            tail_is_b;
    logic            inflight;

    assign accept  = (state_q == ST_IDLE) && start_i;
    assign granted = rd_req_o && rd_gnt_i;

    mvd_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .load_i      (granted),
        .is_b_i      (state_q == ST_REQ_B),
        .tail_vld_o  (tail_vld),
        .tail_is_b_o (tail_is_b),
        .inflight_o  (inflight)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the candidate addresses of the accepted PU.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_addr_q <= '0;
            b_addr_q <= '0;
        end else if (accept) begin
            a_addr_q <= a_addr_i;
            b_addr_q <= b_addr_i;
        end
    end

    // Capture returning MVs on the tag tail; cleared when a new PU starts.
    always_ff @(posedge clk) begin
        // NOTE: the result registers drive outputs directly, so they are reset
        // to read 0 after reset instead of showing a stale MV.
        if (rst) begin
            mv_a_q     <= '0;
            mv_a_vld_q <= 1'b0;
            mv_b_q     <= '0;
            mv_b_vld_q <= 1'b0;
        end else if (accept) begin
            mv_a_q     <= '0;
            mv_a_vld_q <= 1'b0;
            mv_b_q     <= '0;
            mv_b_vld_q <= 1'b0;
        end else if (tail_vld) begin
            if (tail_is_b) begin
                mv_b_q     <= rd_data_i;
                mv_b_vld_q <= 1'b1;
            end else begin
                mv_a_q     <= rd_data_i;
                mv_a_vld_q <= 1'b1;
            end
        end
    end

    // Next-state logic plus the read-port request, select and address.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        rd_req_o  = 1'b0;
        rd_sel_o  = RD_SEL_NONE;
        rd_addr_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (cand_present(a_addr_i[7:6])) begin
                        state_d = ST_REQ_A;
                    end else if (cand_present(b_addr_i[8:7])) begin
                        state_d = ST_REQ_B;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_REQ_A: begin
                rd_req_o  = 1'b1;
                rd_sel_o  = cand_sel(a_addr_q[7:6], 1'b0);
                rd_addr_o = {a_addr_q[5:3], 1'b0, a_addr_q[2:0]};
                if (rd_gnt_i) begin
                    state_d = cand_present(b_addr_q[8:7]) ? ST_REQ_B : ST_DRAIN;
                end
            end
            ST_REQ_B: begin
                rd_req_o  = 1'b1;
                rd_sel_o  = cand_sel(b_addr_q[8:7], 1'b1);
                rd_addr_o = b_addr_q[6:0];
                if (rd_gnt_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!inflight) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign mv_a_o       = mv_a_q;
    assign mv_a_valid_o = mv_a_vld_q;
    assign mv_b_o       = mv_b_q;
    assign mv_b_valid_o = mv_b_vld_q;

endmodule

// File: tb/tb_mvd_can_mv_fetch_ctrl.sv
// Directed bench for mvd_can_mv_fetch_ctrl: one instance with RD_LAT=1 and
// one with RD_LAT=3 share all inputs; each has its own MV storage responder.
module tb_mvd_can_mv_fetch_ctrl;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_i;
    logic [7:0]  a_addr_i;
    logic [8:0]  b_addr_i;
    logic        rd_gnt_i;

    logic        busy1, done1, req1, mvav1, mvbv1;
    logic [1:0]  sel1;
    logic [6:0]  addr1;
    logic [31:0] data1, mva1, mvb1;

    logic        busy3, done3, req3, mvav3, mvbv3;
    logic [1:0]  sel3;
    logic [6:0]  addr3;
    logic [31:0] data3, mva3, mvb3;

    int n_tests = 0;
    int n_fail  = 0;

    mvd_can_mv_fetch_ctrl #(.MV_W(32), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .start_i(start_i), .a_addr_i(a_addr_i), .b_addr_i(b_addr_i),
        .busy_o(busy1), .done_o(done1), .rd_req_o(req1), .rd_sel_o(sel1), .rd_addr_o(addr1),
        .rd_gnt_i(rd_gnt_i), .rd_data_i(data1), .mv_a_o(mva1), .mv_a_valid_o(mvav1),
        .mv_b_o(mvb1), .mv_b_valid_o(mvbv1)
    );

    mvd_can_mv_fetch_ctrl #(.MV_W(32), .RD_LAT(3)) u3 (
        .clk(clk), .rst(rst), .start_i(start_i), .a_addr_i(a_addr_i), .b_addr_i(b_addr_i),
        .busy_o(busy3), .done_o(done3), .rd_req_o(req3), .rd_sel_o(sel3), .rd_addr_o(addr3),
        .rd_gnt_i(rd_gnt_i), .rd_data_i(data3), .mv_a_o(mva3), .mv_a_valid_o(mvav3),
        .mv_b_o(mvb3), .mv_b_valid_o(mvbv3)
    );

    // Storage model: each (select, address) pair holds a distinct MV word.
    function automatic logic [31:0] mv_of(input logic [1:0] sel, input logic [6:0] addr);
        return {8'hA0, 6'b0, sel, 9'h0, addr};
    endfunction

    // Responder for RD_LAT=1: data valid in the cycle after the grant edge.
    always @(posedge clk) begin : resp1
        logic        g;
        logic [31:0] d;
        g = req1 && rd_gnt_i;
        d = mv_of(sel1, addr1);
        #1;
        data1 = g ? d : JUNK;
    end

    // Responder for RD_LAT=3: three-stage delay of granted reads.
    logic        r3_v [3];
    logic [31:0] r3_d [3];
    always @(posedge clk) begin : resp3
        logic        g;
        logic [31:0] d;
        g = req3 && rd_gnt_i;
        d = mv_of(sel3, addr3);
        #1;
        r3_v[2] = r3_v[1]; r3_d[2] = r3_d[1];
        r3_v[1] = r3_v[0]; r3_d[1] = r3_d[0];
        r3_v[0] = g;       r3_d[0] = d;
        data3 = r3_v[2] ? r3_d[2] : JUNK;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // done1/done3: index c of the cycle following start edge t+c in which
    // done_o is first seen high.
    typedef struct {
        logic [7:0] a;
        logic [8:0] b;
        int         wait_a;
        logic       a_vld;
        logic [1:0] a_sel;
        logic [6:0] a_adr;
        logic       b_vld;
        logic [1:0] b_sel;
        logic [6:0] b_adr;
        int         done1;
        int         done3;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int i);
        vec_t       v;
        int         d1, d3, nd1, nd3, n1, n3, nexp;
        logic [1:0] rs1 [2], rs3 [2], es [2];
        logic [6:0] ra1 [2], ra3 [2], ea [2];
        logic       pend1, pend3, stab1, stab3, busy0;
        logic [1:0] ps1, ps3;
        logic [6:0] pa1, pa3;
        logic [31:0] exp_a, exp_b;
        v = vecs[i];
        d1 = -1; d3 = -1; nd1 = 0; nd3 = 0; n1 = 0; n3 = 0;
        pend1 = 1'b0; pend3 = 1'b0; stab1 = 1'b1; stab3 = 1'b1; busy0 = 1'b0;
        ps1 = '0; ps3 = '0; pa1 = '0; pa3 = '0;
        for (int k = 0; k < 2; k++) begin
            rs1[k] = '0; rs3[k] = '0; ra1[k] = '0; ra3[k] = '0; es[k] = '0; ea[k] = '0;
        end

        @(posedge clk); #1;
        a_addr_i = v.a; b_addr_i = v.b; start_i = 1'b1; rd_gnt_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 0; c < 14; c++) begin
            rd_gnt_i = (c >= v.wait_a);
            @(negedge clk);
            if (c == 0) busy0 = busy1;
            if (done1) begin nd1++; if (d1 < 0) d1 = c; end
            if (done3) begin nd3++; if (d3 < 0) d3 = c; end
            if (req1) begin
                if (pend1 && (sel1 !== ps1 || addr1 !== pa1)) stab1 = 1'b0;
                ps1 = sel1; pa1 = addr1;
                if (rd_gnt_i) begin
                    if (n1 < 2) begin rs1[n1] = sel1; ra1[n1] = addr1; end
                    n1++; pend1 = 1'b0;
                end else pend1 = 1'b1;
            end
            if (req3) begin
                if (pend3 && (sel3 !== ps3 || addr3 !== pa3)) stab3 = 1'b0;
                ps3 = sel3; pa3 = addr3;
                if (rd_gnt_i) begin
                    if (n3 < 2) begin rs3[n3] = sel3; ra3[n3] = addr3; end
                    n3++; pend3 = 1'b0;
                end else pend3 = 1'b1;
            end
            @(posedge clk); #1;
        end

        nexp = 0;
        if (v.a_vld) begin es[nexp] = v.a_sel; ea[nexp] = v.a_adr; nexp++; end
        if (v.b_vld) begin es[nexp] = v.b_sel; ea[nexp] = v.b_adr; nexp++; end
        exp_a = v.a_vld ? mv_of(v.a_sel, v.a_adr) : 32'h0;
        exp_b = v.b_vld ? mv_of(v.b_sel, v.b_adr) : 32'h0;

        check($sformatf("v%0d nreq lat1", i), n1, nexp);
        check($sformatf("v%0d nreq lat3", i), n3, nexp);
        for (int k = 0; k < nexp; k++) begin
            check($sformatf("v%0d req%0d sel lat1", i, k), rs1[k], es[k]);
            check($sformatf("v%0d req%0d addr lat1", i, k), ra1[k], ea[k]);
            check($sformatf("v%0d req%0d sel lat3", i, k), rs3[k], es[k]);
            check($sformatf("v%0d req%0d addr lat3", i, k), ra3[k], ea[k]);
        end
        check($sformatf("v%0d req stable lat1", i), stab1, 1'b1);
        check($sformatf("v%0d req stable lat3", i), stab3, 1'b1);
        check($sformatf("v%0d busy after start", i), busy0, 1'b1);
        check($sformatf("v%0d done cycle lat1", i), d1, v.done1);
        check($sformatf("v%0d done cycle lat3", i), d3, v.done3);
        check($sformatf("v%0d done pulses lat1", i), nd1, 1);
        check($sformatf("v%0d done pulses lat3", i), nd3, 1);
        check($sformatf("v%0d idle at end", i), {busy1, busy3}, 2'b00);
        check($sformatf("v%0d mv_a lat1", i), {mvav1, mva1}, {v.a_vld, exp_a});
        check($sformatf("v%0d mv_b lat1", i), {mvbv1, mvb1}, {v.b_vld, exp_b});
        check($sformatf("v%0d mv_a lat3", i), {mvav3, mva3}, {v.a_vld, exp_a});
        check($sformatf("v%0d mv_b lat3", i), {mvbv3, mvb3}, {v.b_vld, exp_b});
    endtask

    initial begin : main
        int d1, d3;
        logic seen_done, seen_vld;

        //             a             b               wait a_vld a_sel a_adr  b_vld b_sel b_adr  d1 d3
        vecs[0] = '{8'b10_011_010, 9'b10_001_0100, 0, 1'b1, 2'd3, 7'h32, 1'b1, 2'd3, 7'h14, 3, 5};
        vecs[1] = '{8'b01_101_111, 9'b00_110_0101, 0, 1'b1, 2'd1, 7'h57, 1'b0, 2'd0, 7'h00, 2, 4};
        vecs[2] = '{8'b00_111_111, 9'b00_111_1111, 0, 1'b0, 2'd0, 7'h00, 1'b0, 2'd0, 7'h00, 0, 0};
        vecs[3] = '{8'b10_100_001, 9'b01_010_0011, 3, 1'b1, 2'd3, 7'h41, 1'b1, 2'd2, 7'h23, 6, 8};
        vecs[4] = '{8'b11_010_010, 9'b01_111_1000, 0, 1'b0, 2'd0, 7'h00, 1'b1, 2'd2, 7'h78, 2, 4};
        vecs[5] = '{8'b01_000_000, 9'b11_001_0001, 0, 1'b1, 2'd1, 7'h00, 1'b0, 2'd0, 7'h00, 2, 4};

        for (int k = 0; k < 3; k++) begin r3_v[k] = 1'b0; r3_d[k] = '0; end
        data1 = JUNK; data3 = JUNK;
        rst = 1'b1; start_i = 1'b0; a_addr_i = '0; b_addr_i = '0; rd_gnt_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ctl lat1", {busy1, done1, req1, sel1, addr1}, 12'h0);
        check("reset ctl lat3", {busy3, done3, req3, sel3, addr3}, 12'h0);
        check("reset mv lat1", {mvav1, mva1, mvbv1, mvb1}, 66'h0);
        check("reset mv lat3", {mvav3, mva3, mvbv3, mvb3}, 66'h0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i);

        // start_i pulsed while busy must not disturb the running PU.
        @(posedge clk); #1;
        a_addr_i = vecs[0].a; b_addr_i = vecs[0].b; start_i = 1'b1; rd_gnt_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        d1 = -1; d3 = -1;
        for (int c = 0; c < 14; c++) begin
            if (c == 1) begin start_i = 1'b1; a_addr_i = 8'b01_000_001; b_addr_i = 9'b01_000_0001; end
            else start_i = 1'b0;
            @(negedge clk);
            if (done1 && d1 < 0) d1 = c;
            if (done3 && d3 < 0) d3 = c;
            @(posedge clk); #1;
        end
        check("busy start done lat1", d1, 3);
        check("busy start done lat3", d3, 5);
        check("busy start mv_a lat1", {mvav1, mva1}, {1'b1, mv_of(2'd3, 7'h32)});
        check("busy start mv_b lat1", {mvbv1, mvb1}, {1'b1, mv_of(2'd3, 7'h14)});
        check("busy start mv_a lat3", {mvav3, mva3}, {1'b1, mv_of(2'd3, 7'h32)});
        check("busy start mv_b lat3", {mvbv3, mvb3}, {1'b1, mv_of(2'd3, 7'h14)});
        check("busy start idle", {busy1, busy3}, 2'b00);

        // Reset while the RD_LAT=1 instance is in DRAIN.
        @(posedge clk); #1;
        a_addr_i = vecs[0].a; b_addr_i = vecs[0].b; start_i = 1'b1; rd_gnt_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset drain busy", busy1, 1'b1);
        check("pre-reset mv_a captured", mvav1, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("drain reset ctl lat1", {busy1, done1, req1, sel1, addr1}, 12'h0);
        check("drain reset mv lat1", {mvav1, mva1, mvbv1, mvb1}, 66'h0);
        check("drain reset ctl lat3", {busy3, done3, req3, sel3, addr3}, 12'h0);
        rst = 1'b0;
        seen_done = 1'b0; seen_vld = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done1 || done3 || busy1 || busy3) seen_done = 1'b1;
            if (mvav1 || mvbv1 || mvav3 || mvbv3) seen_vld = 1'b1;
        end
        check("after reset no done/busy", seen_done, 1'b0);
        check("after reset no capture", seen_vld, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
